// File: rtl/bitcell_access_controller.sv
// Two-requester access sequencer for the NAND-latch bitcell array: arbitrates, then drives
// decoder adr/select with a one-cycle guard band on each side of select. Build macro: FIXED_PRIO_EN.
//
// state  | meaning
// IDLE   | waiting, req sampled only here
// SETUP  | mem_adr driven, select still low
// ACCESS | select high for ACCESS_CYCLES cycles
// HOLD   | select low, mem_adr held
// DONE   | ack pulse to the winner
module bitcell_access_controller #(
    parameter int ADR_W         = 3,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2    // must be >= 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we_in,
    input  logic [ADR_W-1:0]  adr0,
    input  logic [ADR_W-1:0]  adr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADR_W-1:0]  mem_adr,
    output logic              mem_select,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_next;

    logic              grant;
    logic              last_grant;
    logic              win;
    logic              we_lat;
    logic [ADR_W-1:0]  adr_lat;
    logic [DATA_W-1:0] wdata_lat;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        ack_d;
    logic [DATA_W-1:0] rdata_d;
    logic              busy_d;
    logic [ADR_W-1:0]  mem_adr_d;
    logic              mem_select_d;
    logic              mem_we_d;
    logic [DATA_W-1:0] mem_wdata_d;

    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
`ifdef FIXED_PRIO_EN
            2'b11:   grant = 1'b0;
`else
            2'b11:   grant = ~last_grant;
`endif
            default: grant = 1'b0;
        endcase
    end

    // Winner's request is captured at the IDLE edge; the requester may change it afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win        <= 1'b0;
            we_lat     <= 1'b0;
            adr_lat    <= '0;
            wdata_lat  <= '0;
            last_grant <= 1'b1;
        end else if (state == IDLE && req != 2'b00) begin
            win       <= grant;
            we_lat    <= we_in[grant];
            adr_lat   <= grant ? adr1 : adr0;
            wdata_lat <= grant ? wdata1 : wdata0;
`ifndef FIXED_PRIO_EN
            last_grant <= grant;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == SETUP) begin
            cnt <= CNT_LOAD;
        end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req != 2'b00) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (cnt == '0) state_next = HOLD;
            HOLD:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output values are computed for the state being entered, so every output is a flop.
    always_comb begin
        ack_d        = 2'b00;
        busy_d       = (state_next != IDLE);
        mem_adr_d    = mem_adr;
        mem_select_d = 1'b0;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata;
        rdata_d      = rdata;
        case (state_next)
            SETUP:   mem_adr_d = grant ? adr1 : adr0;
            ACCESS: begin
                mem_select_d = 1'b1;
                mem_we_d     = we_lat;
                mem_wdata_d  = wdata_lat;
            end
            DONE:    ack_d = win ? 2'b10 : 2'b01;
            default: ;
        endcase
        if (state == ACCESS && cnt == '0 && !we_lat) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack        <= 2'b00;
            rdata      <= '0;
            busy       <= 1'b0;
            mem_adr    <= '0;
            mem_select <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            ack        <= ack_d;
            rdata      <= rdata_d;
            busy       <= busy_d;
            mem_adr    <= mem_adr_d;
            mem_select <= mem_select_d;
            mem_we     <= mem_we_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule
